gate_tt_checker: RTL and testbench

Response-side checker for the 2-input gate library. It samples a gate-under-test's inputs (a, b) and output (o) on a valid strobe and compares o against a parameterised truth table. It counts samples and mismatches and tracks coverage of all four input combinations, then reports pass/fail. It sits opposite the stimulus driver in self-checking gate benches and in on-chip gate BIST wrappers.

---
 rtl/gate_tt_checker.sv | 104 ++++++++++
 tb/tb_gate_tt_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Response checker for 2-input gates: compares o against truth table TT.
// Optional GATE_CHK_STOP_ON_ERR_EN ends the run on the first mismatch.
module gate_tt_checker #(
  parameter logic [3:0] TT          = 4'b0111,
  parameter int         CNT_W       = 8,
  parameter int         NUM_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic             a,
  input  logic             b,
  input  logic             o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [3:0]       coverage,
  output logic [1:0]       first_err_idx
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES);

  state_t           state, state_n;
  logic [CNT_W-1:0] err_n, samp_n;
  logic [3:0]       cov_n;
  logic [1:0]       fei_n;
  logic             pass_n;
  logic [1:0]       idx;
  logic             mis;

  assign idx  = {a, b};
  assign mis  = (o != TT[idx]);
  assign busy = (state == CHECK);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      err_cnt       <= '0;
      sample_cnt    <= '0;
      coverage      <= '0;
      first_err_idx <= '0;
      pass          <= 1'b0;
    end else begin
      state         <= state_n;
      err_cnt       <= err_n;
      sample_cnt    <= samp_n;
      coverage      <= cov_n;
      first_err_idx <= fei_n;
      pass          <= pass_n;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_cnt;
    samp_n  = sample_cnt;
    cov_n   = coverage;
    fei_n   = first_err_idx;
    pass_n  = pass;
    unique case (state)
      IDLE, DONE: begin
        // a sample coinciding with start is deliberately dropped
        if (start) begin
          state_n = CHECK;
          err_n   = '0;
          samp_n  = '0;
          cov_n   = '0;
          fei_n   = '0;
          pass_n  = 1'b0;
        end
      end
      CHECK: begin
        if (sample_valid) begin
          if (sample_cnt != '1)
            samp_n = sample_cnt + 1'b1;
          cov_n[idx] = 1'b1;
          if (mis) begin
            if (err_cnt != '1)
              err_n = err_cnt + 1'b1;
            if (err_cnt == '0)
              fei_n = idx;
          end
          if (samp_n == LAST)
            state_n = DONE;
`ifdef GATE_CHK_STOP_ON_ERR_EN
          if (mis)
            state_n = DONE;
`else
`endif
          if (state_n == DONE)
            pass_n = (err_n == '0) && (cov_n == 4'hF);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Scoreboard bench for gate_tt_checker: default NAND instance plus a
// CNT_W=2 / NUM_SAMPLES=3 instance for counter boundaries.
module tb_gate_tt_checker;

  typedef struct packed {
    logic       pass;
    logic [7:0] err;
    logic [7:0] samp;
    logic [3:0] cov;
    logic [1:0] fei;
  } res_t;

  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic start = 0, sample_valid = 0, a = 0, b = 0, o = 0;
  logic busy, done, pass;
  logic [7:0] err_cnt, sample_cnt;
  logic [3:0] coverage;
  logic [1:0] first_err_idx;

  logic start2 = 0, sv2 = 0, a2 = 0, b2 = 0, o2 = 0;
  logic busy2, done2, pass2;
  logic [1:0] err2, samp2;
  logic [3:0] cov2;
  logic [1:0] fei2;

  gate_tt_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .sample_valid(sample_valid), .a(a), .b(b), .o(o),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .sample_cnt(sample_cnt),
    .coverage(coverage), .first_err_idx(first_err_idx)
  );

  gate_tt_checker #(.CNT_W(2), .NUM_SAMPLES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .sample_valid(sv2), .a(a2), .b(b2), .o(o2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .sample_cnt(samp2),
    .coverage(cov2), .first_err_idx(fei2)
  );

  int tests = 0;
  int fails = 0;
  res_t q0[$];
  res_t q1[$];
  logic done_q = 0, done2_q = 0;

  task automatic cmp_r(string name, res_t got, res_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got pass=%0b err=%0d samp=%0d cov=%b fei=%0d, want pass=%0b err=%0d samp=%0d cov=%b fei=%0d",
        name, got.pass, got.err, got.samp, got.cov, got.fei,
        exp.pass, exp.err, exp.samp, exp.cov, exp.fei);
    end
  endtask

  task automatic cmp_v(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, exp);
    end
  endtask

  // monitor: compare results whenever done rises
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q0.size() == 0) cmp_v("unexpected_done", 1, 0);
      else cmp_r("run", {pass, err_cnt, sample_cnt, coverage, first_err_idx},
                 q0.pop_front());
    end
    if (done2 && !done2_q) begin
      if (q1.size() == 0) cmp_v("unexpected_done2", 1, 0);
      else cmp_r("run2", {pass2, 6'd0, err2, 6'd0, samp2, cov2, fei2},
                 q1.pop_front());
    end
    done_q  <= done;
    done2_q <= done2;
  end

  task automatic drive(int u, logic st, logic sv, logic ai, logic bi, logic oi);
    @(negedge clk);
    if (u == 0) {start, sample_valid, a, b, o} = {st, sv, ai, bi, oi};
    else {start2, sv2, a2, b2, o2} = {st, sv, ai, bi, oi};
    @(negedge clk);
    if (u == 0) {start, sample_valid} = 2'b00;
    else {start2, sv2} = 2'b00;
  endtask

  task automatic smp(int u, logic ai, logic bi, logic oi);
    drive(u, 0, 1, ai, bi, oi);
  endtask

  task automatic go(int u);
    drive(u, 1, 0, 0, 0, 0);
  endtask

  task automatic wait_done(int u);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if ((u == 0 ? done : done2) === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) cmp_v("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    cmp_v("reset", {busy, done, pass, err_cnt, sample_cnt, coverage, first_err_idx}, 0);
    rst = 0;

    // reset mid-run
    go(0);
    smp(0, 0, 0, 1);
    smp(0, 0, 1, 1);
    cmp_v("mid_busy_cnt", {busy, sample_cnt}, {1'b1, 8'd2});
    rst = 1;
    #1;
    cmp_v("mid_reset", {busy, done, pass, err_cnt, sample_cnt, coverage, first_err_idx}, 0);
    @(negedge clk);
    rst = 0;

    // good NAND run
    q0.push_back('{1'b1, 8'd0, 8'd4, 4'hF, 2'd0});
    go(0);
    smp(0, 0, 0, 1); smp(0, 0, 1, 1); smp(0, 1, 0, 1); smp(0, 1, 1, 0);
    wait_done(0);

    // bad last sample, restart from DONE
    q0.push_back('{1'b0, 8'd1, 8'd4, 4'hF, 2'd3});
    go(0);
    smp(0, 0, 0, 1); smp(0, 0, 1, 1); smp(0, 1, 0, 1); smp(0, 1, 1, 1);
    wait_done(0);

    // incomplete coverage
    q0.push_back('{1'b0, 8'd0, 8'd4, 4'b0001, 2'd0});
    go(0);
    repeat (4) smp(0, 0, 0, 1);
    wait_done(0);

    // multiple errors; first index is 00
    go(0);
`ifdef GATE_CHK_STOP_ON_ERR_EN
    q0.push_back('{1'b0, 8'd1, 8'd1, 4'b0001, 2'd0});
    smp(0, 0, 0, 0);
`else
    q0.push_back('{1'b0, 8'd2, 8'd4, 4'hF, 2'd0});
    smp(0, 0, 0, 0); smp(0, 0, 1, 0); smp(0, 1, 0, 1); smp(0, 1, 1, 0);
`endif
    wait_done(0);

    // gaps with start pulses during CHECK
    q0.push_back('{1'b0, 8'd1, 8'd4, 4'hF, 2'd2});
    go(0);
    smp(0, 1, 1, 0);
    repeat (2) @(negedge clk);
    go(0);
    smp(0, 0, 0, 1);
    cmp_v("gap_busy_cnt", {busy, sample_cnt}, {1'b1, 8'd2});
    go(0);
    @(negedge clk);
    smp(0, 0, 1, 1);
    smp(0, 1, 0, 0);
    wait_done(0);
    cmp_v("done_hold", {done, busy, sample_cnt}, {1'b1, 1'b0, 8'd4});

    // narrow counters: all-bad run reaches counter maximum
    go(1);
`ifdef GATE_CHK_STOP_ON_ERR_EN
    q1.push_back('{1'b0, 8'd1, 8'd1, 4'b0001, 2'd0});
    smp(1, 0, 0, 0);
`else
    q1.push_back('{1'b0, 8'd3, 8'd3, 4'b0001, 2'd0});
    smp(1, 0, 0, 0); smp(1, 0, 0, 0); smp(1, 0, 0, 0);
`endif
    wait_done(1);
    smp(1, 0, 0, 0);
`ifdef GATE_CHK_STOP_ON_ERR_EN
    cmp_v("done_ignores_sample", {done2, err2, samp2}, {1'b1, 2'd1, 2'd1});
`else
    cmp_v("done_ignores_sample", {done2, err2, samp2}, {1'b1, 2'd3, 2'd3});
`endif

    // start in DONE with simultaneous sample
    drive(1, 1, 1, 0, 0, 0);
    cmp_v("restart_clear", {busy2, done2, err2, samp2, cov2, fei2}, {1'b1, 1'b0, 10'd0});
    q1.push_back('{1'b0, 8'd0, 8'd3, 4'b1001, 2'd0});
    smp(1, 1, 1, 0); smp(1, 1, 1, 0); smp(1, 0, 0, 1);
    wait_done(1);

    repeat (2) @(negedge clk);
    cmp_v("q0_drained", q0.size(), 0);
    cmp_v("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
